freq_meas_ctrl: RTL

//  Parametrised gate-timing controller and edge counter for the frequency meter.

---
 rtl/freq_meas_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/freq_meas_ctrl.sv
// Gate-timing controller and FIN edge counter for the frequency meter.
// Sequences clear / gate / latch and publishes the latched edge count with an overflow flag.
module freq_meas_ctrl #(
    parameter int CNT_W       = 32,
    parameter int GATE_CYCLES = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLKK,
    input  logic             RST,
    input  logic             START,
    input  logic             CONT,
    input  logic             STOP,
    input  logic             FIN,
    output logic             CNT_EN,
    output logic             RST_CNT,
    output logic             LOAD,
    output logic [CNT_W-1:0] RESULT,
    output logic             VALID,
    output logic             OVF,
    output logic             BUSY
);

    localparam int TW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        GATE  = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [TW-1:0]    timer_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic             prev_reg;
    logic             rise;
    logic [CNT_W-1:0] count_reg;
    logic             sticky_ovf_reg;
    logic [CNT_W-1:0] result_reg;
    logic             ovf_reg;
    logic             valid_reg;

    // FIN synchroniser chain; stage 0 is the only flop that sees the asynchronous input
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge CLKK or posedge RST) begin
                if (RST) begin
                    sync_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= FIN;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi > 0) ? gi - 1 : 0];
                end
            end
        end
    endgenerate

    always_ff @(posedge CLKK or posedge RST) begin
        if (RST) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

    always_ff @(posedge CLKK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (STOP) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (START) state_next = CLEAR;
                CLEAR:   state_next = GATE;
                GATE:    if (timer_reg == TIMER_LAST) state_next = LATCH;
                LATCH:   state_next = CONT ? CLEAR : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // An abort landing on the latch cycle must not publish a result
    always_comb begin
        CNT_EN  = (state_reg == GATE);
        RST_CNT = (state_reg == CLEAR);
        LOAD    = (state_reg == LATCH) && !STOP;
        BUSY    = (state_reg != IDLE);
    end

    always_ff @(posedge CLKK or posedge RST) begin
        if (RST) begin
            timer_reg <= '0;
        end else if (state_reg == CLEAR) begin
            timer_reg <= '0;
        end else if (state_reg == GATE) begin
            timer_reg <= timer_reg + 1'b1;
        end
    end

    // Saturating counter: an increment attempt at full scale only sets the sticky flag
    always_ff @(posedge CLKK or posedge RST) begin
        if (RST) begin
            count_reg      <= '0;
            sticky_ovf_reg <= 1'b0;
        end else if (state_reg == CLEAR) begin
            count_reg      <= '0;
            sticky_ovf_reg <= 1'b0;
        end else if ((state_reg == GATE) && rise) begin
            if (count_reg == '1) begin
                sticky_ovf_reg <= 1'b1;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge CLKK or posedge RST) begin
        if (RST) begin
            result_reg <= '0;
            ovf_reg    <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            valid_reg <= LOAD;
            if (LOAD) begin
                result_reg <= count_reg;
                ovf_reg    <= sticky_ovf_reg;
            end
        end
    end

    assign RESULT = result_reg;
    assign OVF    = ovf_reg;
    assign VALID  = valid_reg;

endmodule
